// File: rtl/pll_rst_gen.sv
// PLL lock qualification and system reset sequencer on the reference clock.
// Optional lock-loss counter: define PLL_RST_GEN_LOSS_CNT_EN.
module pll_rst_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 1024,
  parameter int TIMEOUT_CYC = 500000,
  parameter int PLL_RST_CYC = 16,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rstn,
  output logic       ready,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  typedef enum logic [1:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_READY
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rstn_q, sys_rstn_d;
  logic                   ready_q, ready_d;
  logic [7:0]             retry_q, retry_d;
  logic                   lk;

`ifdef PLL_RST_GEN_LOSS_CNT_EN
  logic [7:0]             loss_q, loss_d;
`endif

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pll_lock};
    lk      = sync_q[SYNC_STAGES-1];
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
`ifdef PLL_RST_GEN_LOSS_CNT_EN
    loss_d  = loss_q;
`endif
    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        // lock takes priority over a coincident timeout
        if (lk) begin
          cnt_d   = '0;
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = S_PLL_RST;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end
      end
      S_STABLE: begin
        if (!lk) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == ST_LAST) begin
          cnt_d   = '0;
          state_d = S_READY;
        end
      end
      S_READY: begin
        cnt_d = '0;
        if (!lk) begin
          state_d = S_WAIT_LOCK;
`ifdef PLL_RST_GEN_LOSS_CNT_EN
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`endif
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_PLL_RST;
      end
    endcase
    // outputs registered from the next state so they change with it
    pll_rst_d  = (state_d == S_PLL_RST);
    ready_d    = (state_d == S_READY);
    sys_rstn_d = (state_d == S_READY);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q     <= '0;
      state_q    <= S_PLL_RST;
      cnt_q      <= '0;
      pll_rst_q  <= 1'b1;
      sys_rstn_q <= 1'b0;
      ready_q    <= 1'b0;
      retry_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pll_rst_q  <= pll_rst_d;
      sys_rstn_q <= sys_rstn_d;
      ready_q    <= ready_d;
      retry_q    <= retry_d;
    end
  end

`ifdef PLL_RST_GEN_LOSS_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) loss_q <= '0;
    else       loss_q <= loss_d;
  end
  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'd0;
`endif

  assign pll_rst   = pll_rst_q;
  assign sys_rstn  = sys_rstn_q;
  assign ready     = ready_q;
  assign retry_cnt = retry_q;

endmodule
